// File: rtl/uno_seq.sv
// Command sequencer for the unified MAC/div/exp/log PE: it issues the per-cycle
// control stream for one command and returns the PE result over valid/ready.
module uno_seq #(
  parameter int MAC_BW = 12,
  parameter int ORDER  = 4,
  parameter int LEN_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [MAC_BW-1:0]             cmd_x,
  input  logic [MAC_BW-1:0]             cmd_y,
  input  logic [2*MAC_BW-1:0]           cmd_z,
  input  logic [LEN_W-1:0]              cmd_len,
  input  logic                          opnd_valid,
  output logic                          opnd_ready,
  input  logic [MAC_BW-1:0]             opnd_x,
  input  logic [MAC_BW-1:0]             opnd_y,
  output logic [2+$clog2(ORDER+1)-1:0]  coeff_addr,
  input  logic [MAC_BW-1:0]             coeff_data,
  output logic [1:0]                    uno_op,
  output logic [MAC_BW-1:0]             uno_x,
  output logic [MAC_BW-1:0]             uno_y,
  output logic [2*MAC_BW-1:0]           uno_z,
  output logic [MAC_BW-1:0]             uno_coeff,
  output logic                          uno_first,
  output logic                          uno_last,
  output logic                          uno_acc_en,
  input  logic [2*MAC_BW-1:0]           uno_res,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [2*MAC_BW-1:0]           res_data
);
  localparam int IW = $clog2(ORDER+1);

  typedef enum logic [2:0] {IDLE, POLY, MACC, DRAIN, HOLD} state_t;

  state_t              state, state_nx;
  logic [1:0]          op_q;
  logic [MAC_BW-1:0]   x_q, y_q;
  logic [2*MAC_BW-1:0] z_q;
  logic [LEN_W-1:0]    rem_q;
  logic [IW-1:0]       k_q;
  logic                acc_q;   // a MAC pair has already been accepted

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      rem_q     <= '0;
      k_q       <= '0;
      acc_q     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (cmd_valid) begin
          op_q  <= cmd_op;
          x_q   <= cmd_x;
          y_q   <= cmd_y;
          z_q   <= cmd_z;
          rem_q <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
          k_q   <= '0;
          acc_q <= 1'b0;
        end
        POLY: k_q <= k_q + 1'b1;
        MACC: if (opnd_valid) begin
          rem_q <= rem_q - 1'b1;
          acc_q <= 1'b1;
        end
        DRAIN: begin
          res_valid <= 1'b1;
          res_data  <= uno_res;
        end
        HOLD: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    cmd_ready  = 1'b0;
    opnd_ready = 1'b0;
    coeff_addr = '0;
    uno_op     = '0;
    uno_x      = '0;
    uno_y      = '0;
    uno_z      = '0;
    uno_coeff  = '0;
    uno_first  = 1'b0;
    uno_last   = 1'b0;
    uno_acc_en = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = (cmd_op == 2'b00) ? MACC : POLY;
      end
      POLY: begin
        uno_op    = op_q;
        uno_x     = x_q;
        uno_y     = y_q;
        uno_first = (k_q == '0);
        // Horner walks c[ORDER] down to c[1]; the final cycle carries no coefficient
        if (k_q == IW'(ORDER)) begin
          uno_last = 1'b1;
          state_nx = DRAIN;
        end else begin
          coeff_addr = {op_q, IW'(ORDER) - k_q};
          uno_coeff  = coeff_data;
        end
      end
      MACC: begin
        opnd_ready = 1'b1;
        uno_z      = z_q;
        uno_acc_en = acc_q;
        if (opnd_valid) begin
          uno_x = opnd_x;
          uno_y = opnd_y;
          if (rem_q == LEN_W'(1)) state_nx = DRAIN;
        end
      end
      DRAIN: state_nx = HOLD;
      HOLD:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uno_seq.sv
// Directed bench for uno_seq with a 1-cycle behavioural PE and a synthetic coefficient ROM.
module tb_uno_seq;
  localparam int MAC_BW = 12, ORDER = 4, LEN_W = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 0, cmd_ready;
  logic [1:0]  cmd_op = 0;
  logic [11:0] cmd_x = 0, cmd_y = 0;
  logic [23:0] cmd_z = 0;
  logic [7:0]  cmd_len = 0;
  logic        opnd_valid = 0, opnd_ready;
  logic [11:0] opnd_x = 0, opnd_y = 0;
  logic [4:0]  coeff_addr;
  logic [11:0] coeff_data;
  logic [1:0]  uno_op;
  logic [11:0] uno_x, uno_y, uno_coeff;
  logic [23:0] uno_z, uno_res, res_data;
  logic        uno_first, uno_last, uno_acc_en, res_valid, res_ready = 0;

  int pass = 0, total = 0;

  uno_seq #(.MAC_BW(MAC_BW), .ORDER(ORDER), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z), .cmd_len(cmd_len),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_x(opnd_x), .opnd_y(opnd_y),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data), .uno_op(uno_op), .uno_x(uno_x),
    .uno_y(uno_y), .uno_z(uno_z), .uno_coeff(uno_coeff), .uno_first(uno_first),
    .uno_last(uno_last), .uno_acc_en(uno_acc_en), .uno_res(uno_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data));

  always #5 clk = ~clk;

  // ROM content is a function of the address so a wrong address shows up as wrong data
  assign coeff_data = 12'h100 + {7'd0, coeff_addr};

  always @(posedge clk)
    if (rst) uno_res <= '0;
    else     uno_res <= (uno_acc_en ? uno_res : uno_z) + uno_x * uno_y + {12'd0, uno_coeff};

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_uno"}, {uno_op, uno_first, uno_last, uno_acc_en, uno_x, uno_y}, 0);
    chk({tag, "_uno_z"}, 32'(uno_z), 0);
    chk({tag, "_coeff"}, {15'd0, coeff_addr, uno_coeff}, 0);
    chk({tag, "_opnd_ready"}, 32'(opnd_ready), 0);
  endtask

  initial begin
    logic [4:0] ea;
    tick(); tick();
    #1;
    chk_quiet("rst");
    chk("rst_res_data", 32'(res_data), 0);
    rst = 0;

    // exp, x=0x140, y=3
    cmd_valid = 1; cmd_op = 2'b10; cmd_x = 12'h140; cmd_y = 12'h003; cmd_z = 0;
    #1 chk("exp_cmd_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 0; cmd_op = 2'b01;
    for (int k = 0; k <= ORDER; k++) begin
      #1;
      ea = (k < ORDER) ? {2'b10, 3'(ORDER - k)} : 5'd0;
      chk("exp_addr", 32'(coeff_addr), 32'(ea));
      chk("exp_coeff", 32'(uno_coeff), (k < ORDER) ? 32'(12'h100 + {7'd0, ea}) : 0);
      chk("exp_first", 32'(uno_first), 32'(k == 0));
      chk("exp_last", 32'(uno_last), 32'(k == ORDER));
      chk("exp_opxy", {uno_op, uno_x, uno_y}, {2'b10, 12'h140, 12'h003});
      chk("exp_cmd_ready", 32'(cmd_ready), 0);
      tick();
    end
    #1 chk_quiet("exp_drain");
    tick();
    #1 chk("exp_res_valid", 32'(res_valid), 1);
    chk("exp_res_data", 32'(res_data), 32'h3C0);
    res_ready = 1; tick(); res_ready = 0;
    #1 chk("exp_hs_valid", 32'(res_valid), 0);
    chk("exp_hs_cmd_ready", 32'(cmd_ready), 1);

    // MAC len=3, z=5, back-to-back pairs
    cmd_valid = 1; cmd_op = 0; cmd_len = 3; cmd_z = 5;
    tick();
    cmd_valid = 0;
    opnd_valid = 1; opnd_x = 2; opnd_y = 3;
    #1 chk("mac_opnd_ready", 32'(opnd_ready), 1);
    chk("mac_acc0", 32'(uno_acc_en), 0);
    chk("mac_xyz", {uno_x, uno_y}, {12'd2, 12'd3});
    chk("mac_z", 32'(uno_z), 5);
    tick();
    opnd_x = 4; opnd_y = 1;
    #1 chk("mac_acc1", 32'(uno_acc_en), 1);
    tick();
    opnd_x = 1; opnd_y = 1;
    #1 chk("mac_acc2", 32'(uno_acc_en), 1);
    tick();
    #1 chk("mac_drain_ready", 32'(opnd_ready), 0);
    chk("mac_drain_x", 32'(uno_x), 0);
    opnd_valid = 0;
    tick();
    #1 chk("mac_res_valid", 32'(res_valid), 1);
    chk("mac_res_data", 32'(res_data), 16);

    // backpressure with a second command already offered
    cmd_valid = 1; cmd_op = 0; cmd_len = 2; cmd_z = 7;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_valid", 32'(res_valid), 1);
      chk("bp_data", 32'(res_data), 16);
      chk("bp_cmd_ready", 32'(cmd_ready), 0);
      tick();
    end
    res_ready = 1; tick(); res_ready = 0;
    #1 chk("bp_after_hs_ready", 32'(cmd_ready), 1);
    chk("bp_after_hs_valid", 32'(res_valid), 0);
    tick();
    cmd_valid = 0;

    // MAC len=2 with a 3-cycle gap
    opnd_valid = 1; opnd_x = 3; opnd_y = 3;
    #1 chk("gap_acc0", 32'(uno_acc_en), 0);
    tick();
    opnd_valid = 0; opnd_x = 9; opnd_y = 9;
    for (int i = 0; i < 3; i++) begin
      #1 chk("gap_xy", {uno_x, uno_y}, 0);
      chk("gap_acc", 32'(uno_acc_en), 1);
      chk("gap_ready", 32'(opnd_ready), 1);
      tick();
    end
    opnd_valid = 1; opnd_x = 2; opnd_y = 2;
    #1 chk("gap_acc1", 32'(uno_acc_en), 1);
    tick();
    opnd_valid = 0;
    tick();
    #1 chk("gap_res_valid", 32'(res_valid), 1);
    chk("gap_res_data", 32'(res_data), 20);
    res_ready = 1; tick(); res_ready = 0;

    // reset during POLY at k=2
    cmd_valid = 1; cmd_op = 2'b01; cmd_x = 5; cmd_y = 6;
    tick();
    cmd_valid = 0;
    tick(); tick();
    #1 chk("rpoly_addr", 32'(coeff_addr), 32'({2'b01, 3'd2}));
    rst = 1; tick(); rst = 0;
    opnd_valid = 1;
    #1 chk_quiet("rpoly");
    chk("rpoly_cmd_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 8; i++) begin
      #1 chk("rpoly_no_res", {res_valid, opnd_ready}, 0);
      tick();
    end
    opnd_valid = 0;
    cmd_valid = 1;
    tick();
    cmd_valid = 0;
    for (int i = 0; i <= ORDER; i++) tick();
    #1 chk("div_drain_valid", 32'(res_valid), 0);
    tick();
    #1 chk("div_res_valid", 32'(res_valid), 1);
    chk("div_res_data", 32'(res_data), 30);
    res_ready = 1; tick(); res_ready = 0;

    // len=0 behaves as len=1
    cmd_valid = 1; cmd_op = 0; cmd_len = 0; cmd_z = 2;
    tick();
    cmd_valid = 0;
    opnd_valid = 1; opnd_x = 3; opnd_y = 4;
    #1 chk("len0_ready", 32'(opnd_ready), 1);
    tick();
    opnd_x = 5; opnd_y = 5;
    #1 chk("len0_drain_ready", 32'(opnd_ready), 0);
    chk("len0_drain_x", 32'(uno_x), 0);
    tick();
    opnd_valid = 0;
    #1 chk("len0_res_valid", 32'(res_valid), 1);
    chk("len0_res_data", 32'(res_data), 14);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
